led_event_blinker: RTL and testbench

Output-side companion to the team's button debouncer: it converts clean, single-cycle event pulses into a visible LED blink sequence, one blink per event. Events that arrive while a blink is in progress are counted and played back in order, with saturation and overflow reporting. The block sits between the control logic and the board LED pin, and shares the debouncer's `FREQUENCY` convention for millisecond timing.

---
 rtl/flutter_pkg.sv | 17 +
 rtl/ms_interval_timer.sv | 24 ++
 rtl/led_event_blinker.sv | 85 ++++++++
 tb/tb_led_event_blinker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/flutter_pkg.sv
// Shared definitions for the button-flutter family: debouncer and LED blinker.
// Holds the blinker state encodings and millisecond-to-cycle conversion.
package flutter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b11
  } state_t;

  localparam int DEBOUNCE_MS = 20;

  function automatic int ms_to_cycles(input int ms, input int freq_mhz);
    return ms * 1000 * freq_mhz;
  endfunction

endpackage

// File: rtl/ms_interval_timer.sv
// Up-counter with synchronous clear and a terminal-count compare.
// The terminal value is an input so one timer can serve several intervals.
module ms_interval_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 1'b1;
  end

  assign tc = (r_cnt == term);

endmodule

// File: rtl/led_event_blinker.sv
// Turns single-cycle event pulses into one LED blink each, queueing events
// that arrive mid-blink in a saturating pending counter.
module led_event_blinker
  import flutter_pkg::*;
#(
  parameter int FREQUENCY = 5,
  parameter int ON_MS     = 100,
  parameter int OFF_MS    = 100,
  parameter int PEND_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              event_i,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int T_ON  = ms_to_cycles(ON_MS, FREQUENCY);
  localparam int T_OFF = ms_to_cycles(OFF_MS, FREQUENCY);
  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [PEND_W-1:0] P_MAX = '1;

  if (T_ON < 1 || T_OFF < 1) begin : g_bad_timing
    $error("led_event_blinker: T_ON and T_OFF must both be at least one cycle");
  end

  state_t            r_state, w_next;
  logic [PEND_W-1:0] r_pending;
  logic              r_led, r_busy, r_overflow;
  logic              w_tc, w_start, w_full;
  logic [TW-1:0]     w_term;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_pending != '0) w_next = ON;
      ON:      if (w_tc) w_next = OFF;
      OFF:     if (w_tc) w_next = (r_pending != '0) ? ON : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Every entry into ON consumes one queued event.
  assign w_start = (w_next == ON) && (r_state != ON);
  assign w_full  = (r_pending == P_MAX);
  assign w_term  = (r_state == ON) ? TW'(T_ON - 1) : TW'(T_OFF - 1);

  ms_interval_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((w_next != r_state) || (r_state == IDLE)),
    .enable (r_state != IDLE),
    .term   (w_term),
    .tc     (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_pending  <= '0;
    end else begin
      r_state    <= w_next;
      r_led      <= (w_next == ON);
      r_busy     <= (w_next != IDLE);
      r_overflow <= event_i && w_full && !w_start;
      case ({event_i, w_start})
        2'b10:   if (!w_full) r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: ;
      endcase
    end
  end

  assign led      = r_led;
  assign busy     = r_busy;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_led_event_blinker.sv
// Bench for led_event_blinker: blink-schedule reference model plus directed
// scenarios and random event traffic.
module tb_led_event_blinker;

  localparam int T_ON  = 1000;
  localparam int T_OFF = 1000;
  localparam int TT    = T_ON + T_OFF;
  localparam int PMAX  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       event_i;
  logic       led, busy, overflow;
  logic [1:0] pending;

  led_event_blinker #(.FREQUENCY(1), .ON_MS(1), .OFF_MS(1), .PEND_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .event_i  (event_i),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int c = 0;
  int m_pend, m_start;
  bit m_ovf;
  int rises, ovf_cnt, peak, last_rise, last_fall, busy_fall, fall0;
  int rise_q[$];
  logic prev_led, prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_start = -1; m_ovf = 0;
    prev_led = 1'b0; prev_busy = 1'b0;
  endtask

  task automatic stats_clear();
    rises = 0; ovf_cnt = 0; peak = 0; rise_q.delete();
  endtask

  // A blink started at edge s owns edges s..s+TT-1; the next start may
  // happen at edge s+TT or any later edge while events are queued.
  task automatic step(input bit ev);
    bit st;
    event_i = ev;
    @(posedge clk);
    c++;
    st = (m_pend > 0) && (m_start < 0 || c - m_start >= TT);
    m_ovf = 0;
    if (st) m_start = c;
    if (ev && !st) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
    end else if (!ev && st) begin
      m_pend--;
    end
    #1;
    chk("led", 32'(led), 32'(m_start >= 0 && c - m_start < T_ON));
    chk("busy", 32'(busy), 32'(m_start >= 0 && c - m_start < TT));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (led && !prev_led) begin rises++; last_rise = c; rise_q.push_back(c); end
    if (!led && prev_led) last_fall = c;
    if (!busy && prev_busy) busy_fall = c;
    if (overflow) ovf_cnt++;
    if (int'(pending) > peak) peak = int'(pending);
    prev_led = led; prev_busy = busy;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  initial begin
    int ev_c, s;
    rst_n = 1'b0; event_i = 1'b0;
    model_reset(); stats_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    run(10);

    // single event
    stats_clear();
    ev_c = c + 1;
    step(1'b1);
    run(TT + 100);
    chk("s1_latency", 32'(last_rise - ev_c), 1);
    chk("s1_width", 32'(last_fall - last_rise), T_ON);
    chk("s1_busy_len", 32'(busy_fall - last_rise), TT);
    chk("s1_blinks", 32'(rises), 1);

    // three back-to-back events
    stats_clear();
    repeat (3) step(1'b1);
    run(3 * TT + 100);
    chk("s2_peak", 32'(peak), 2);
    chk("s2_blinks", 32'(rises), 3);
    if (rise_q.size() == 3) begin
      chk("s2_gap1", 32'(rise_q[1] - rise_q[0]), TT);
      chk("s2_gap2", 32'(rise_q[2] - rise_q[1]), TT);
    end
    chk("s2_width", 32'(last_fall - last_rise), T_ON);

    // event held six cycles from idle
    stats_clear();
    repeat (6) step(1'b1);
    run(4 * TT + 100);
    chk("s3_peak", 32'(peak), 3);
    chk("s3_overflows", 32'(ovf_cnt), 2);
    chk("s3_blinks", 32'(rises), 4);

    // event coincident with a start while pending is full
    stats_clear();
    step(1'b1);
    step(1'b0);
    s = c;
    repeat (3) step(1'b1);
    run(TT - 4);
    step(1'b1);
    chk("s4_start_edge", 32'(c - s), TT);
    chk("s4_pending", 32'(pending), 3);
    chk("s4_no_ovf", 32'(overflow), 0);
    chk("s4_led", 32'(led), 1);
    run(3 * TT + 100);
    chk("s4_ovf_total", 32'(ovf_cnt), 0);

    // asynchronous reset mid-blink
    stats_clear();
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    run(496);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_led", 32'(led), 0);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_pending", 32'(pending), 0);
    chk("s5_overflow", 32'(overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset(); stats_clear();
    run(3000);
    chk("s5_no_blink", 32'(rises), 0);
    step(1'b1);
    run(TT + 100);
    chk("s5_new_blink", 32'(rises), 1);

    // event in the final OFF cycle with nothing queued
    stats_clear();
    step(1'b1);
    step(1'b0);
    s = c;
    run(TT - 1);
    fall0 = last_fall;
    step(1'b1);
    run(TT + 100);
    chk("s6_fall", 32'(fall0 - s), T_ON);
    chk("s6_off_gap", 32'(last_rise - fall0), T_OFF + 1);
    chk("s6_blinks", 32'(rises), 2);

    // random traffic
    stats_clear();
    for (int i = 0; i < 6000; i++) step(1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)));
    run(4 * TT + 100);
    chk("rand_drained", 32'(pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
